// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-port SRAM between the CPU MEM stage
// and a host requester held in a one-entry buffer. The CPU wins by default; a held
// host request is forced through after STARVE_MAX consecutive losses.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU MEM stage
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    // Host requester
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_wen,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    // SRAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {StEmpty, StPending} host_state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    host_state_e       state_q, state_d;
    logic              hreq_wen_q;
    logic [ADDR_W-1:0] hreq_addr_q;
    logic [DATA_W-1:0] hreq_wdata_q;
    logic [3:0]        starve_q, starve_d;
    logic              tag_valid_q, tag_valid_d;
    logic              tag_host_q, tag_host_d;
    logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

    logic host_grant, cpu_grant, capture;
    logic tag_cpu_hit, tag_host_hit;

    // Grant decision, SRAM port mux and stall; everything is suppressed during reset.
    always_comb begin
        host_grant = 1'b0;
        cpu_grant  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        if (!rst) begin
            host_grant = (state_q == StPending) && (!cpu_req || starve_q == StarveMax);
            cpu_grant  = cpu_req && !host_grant;
        end
        if (host_grant) begin
            mem_addr  = hreq_addr_q;
            mem_wdata = hreq_wdata_q;
            mem_wen   = hreq_wen_q;
            mem_ren   = !hreq_wen_q;
        end else if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = !cpu_wen;
        end
        cpu_stall  = cpu_req && host_grant;
        host_ready = !rst && (state_q == StEmpty);
    end

    // Holding-register state, starvation counter and read-tag next state.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        capture  = host_valid && host_ready;
        if (host_grant) begin
            state_d = StEmpty;
        end else if (capture) begin
            state_d = StPending;
        end
        if (host_grant || state_q == StEmpty) begin
            starve_d = 4'd0;
        end else if (cpu_grant && starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
        tag_valid_d = mem_ren;
        tag_host_d  = host_grant;
    end

    // Read return routing: live SRAM data on the cycle after a read grant, else the held value.
    always_comb begin
        tag_cpu_hit  = !rst && tag_valid_q && !tag_host_q;
        tag_host_hit = !rst && tag_valid_q && tag_host_q;
        host_rvalid  = tag_host_hit;
        cpu_rdata    = tag_cpu_hit ? mem_rdata : cpu_rdata_q;
        host_rdata   = tag_host_hit ? mem_rdata : host_rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            hreq_wen_q   <= 1'b0;
            hreq_addr_q  <= '0;
            hreq_wdata_q <= '0;
            starve_q     <= 4'd0;
            tag_valid_q  <= 1'b0;
            tag_host_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tag_valid_q <= tag_valid_d;
            tag_host_q  <= tag_host_d;
            if (capture) begin
                hreq_wen_q   <= host_wen;
                hreq_addr_q  <= host_addr;
                hreq_wdata_q <= host_wdata;
            end
            if (tag_cpu_hit) cpu_rdata_q <= mem_rdata;
            if (tag_host_hit) host_rdata_q <= mem_rdata;
        end
    end

endmodule
